rr_stream_mux2: RTL and testbench



---
 rtl/rr_stream_mux2.sv | 84 ++++++++
 tb/tb_rr_stream_mux2.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux2.sv
// Two-input valid/ready stream merger with round-robin arbitration.
// One registered output stage: an accepted word appears on out_* the next cycle,
// and the stage can refill in the same cycle it drains, so throughput is one word/cycle.
module rr_stream_mux2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_sel_q, out_sel_d;
  // Source of the most recently accepted word; the other source wins a tie.
  logic             last_sel_q, last_sel_d;

  logic can_load;
  logic grant_a, grant_b;
  logic accept_a, accept_b;

  // Arbitration and handshake: grant only depends on valids and the priority bit.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    grant_a  = a_valid && (!b_valid || last_sel_q);
    grant_b  = b_valid && (!a_valid || !last_sel_q);
    // Readies are held low during reset so no input handshake completes in that cycle.
    a_ready  = can_load && grant_a && !rst;
    b_ready  = can_load && grant_b && !rst;
    accept_a = a_valid && a_ready;
    accept_b = b_valid && b_ready;
  end

  // Next-state for the output register and priority bit.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_sel_d  = last_sel_q;
    if (accept_a) begin
      out_valid_d = 1'b1;
      out_data_d  = a_data;
      out_sel_d   = 1'b0;
      last_sel_d  = 1'b0;
    end else if (accept_b) begin
      out_valid_d = 1'b1;
      out_data_d  = b_data;
      out_sel_d   = 1'b1;
      last_sel_d  = 1'b1;
    end else if (out_ready) begin
      // Drain without refill: payload and source are left as they were.
      out_valid_d = 1'b0;
    end
  end

  // State register; reset seeds last_sel to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 1'b0;
      last_sel_q  <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_sel_q  <= last_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux2.sv
// Scoreboard bench for rr_stream_mux2: tests push expected {sel, data} words,
// a monitor pops and compares on every output handshake.
module tb_rr_stream_mux2;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid, b_valid;
  logic [WIDTH-1:0] a_data, b_data;
  logic             a_ready, b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;

  int n_pass  = 0;
  int n_total = 0;

  logic [WIDTH:0]   exp_q[$];   // {sel, data}
  logic [WIDTH-1:0] src_a[$];
  logic [WIDTH-1:0] src_b[$];
  logic             a_en, b_en;
  logic             a_fire, b_fire;

  rr_stream_mux2 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Producers offer the head of their queue while enabled.
  task automatic refresh();
    a_valid = a_en && (src_a.size() != 0);
    b_valid = b_en && (src_b.size() != 0);
    a_data  = a_valid ? src_a[0] : '0;
    b_data  = b_valid ? src_b[0] : '0;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Called at the negedge: latch input handshakes, step past the posedge, advance producers.
  task automatic tick();
    a_fire = a_valid && a_ready;
    b_fire = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (a_fire) void'(src_a.pop_front());
    if (b_fire) void'(src_b.pop_front());
    refresh();
  endtask

  task automatic cycle();
    at_neg();
    tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    a_en = 1'b0;
    b_en = 1'b0;
    out_ready = 1'b0;
    src_a.delete();
    src_b.delete();
    refresh();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 30) begin
      cycle();
      i++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Output monitor: every output handshake outside reset must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {out_sel, out_data}, 0);
      end else begin
        chk("out_word", {out_sel, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    a_fire = 1'b0;
    b_fire = 1'b0;
    apply_reset();

    // Reset then idle.
    at_neg();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("idle_a_ready", a_ready, 0);
    chk("idle_b_ready", b_ready, 0);
    tick();

    // Single source A, back to back.
    out_ready = 1'b1;
    a_en = 1'b1;
    src_a = '{8'h11, 8'h22, 8'h33};
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b0, 8'h33});
    refresh();
    at_neg();
    chk("single_a_ready", a_ready, 1);
    chk("single_b_ready", b_ready, 0);
    chk("single_pre_valid", out_valid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [WIDTH-1:0] want;
      want = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'h33;
      at_neg();
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, want);
      chk("single_sel", out_sel, 0);
      chk("single_b_ready_low", b_ready, 0);
      tick();
    end
    at_neg();
    chk("single_post_valid", out_valid, 0);
    tick();

    // Tie alternation from a fresh reset: A wins first.
    apply_reset();
    out_ready = 1'b1;
    a_en = 1'b1;
    b_en = 1'b1;
    src_a = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    src_b = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] av, bv;
      av = 8'hA0 + 8'(i);
      bv = 8'hB0 + 8'(i);
      exp_q.push_back({1'b0, av});
      exp_q.push_back({1'b1, bv});
    end
    refresh();
    at_neg();
    chk("tie_first_a_ready", a_ready, 1);
    chk("tie_first_b_ready", b_ready, 0);
    tick();
    drain("tie");

    // Backpressure: B loads 0x5C, stall 3 cycles while A offers 0x77.
    a_en = 1'b0;
    b_en = 1'b1;
    src_b = '{8'h5C};
    exp_q.push_back({1'b1, 8'h5C});
    refresh();
    cycle();
    out_ready = 1'b0;
    a_en = 1'b1;
    src_a = '{8'h77};
    refresh();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h5C);
      chk("stall_sel", out_sel, 1);
      chk("stall_a_ready", a_ready, 0);
      chk("stall_b_ready", b_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h77});
    at_neg();
    chk("refill_a_ready", a_ready, 1);
    tick();
    at_neg();
    chk("refill_data", out_data, 8'h77);
    chk("refill_sel", out_sel, 0);
    tick();
    drain("bp");

    // Stall does not rotate priority: B wins the tie, stall 5, then A is next.
    src_a = '{8'hC1, 8'hC2};
    src_b = '{8'hD1, 8'hD2};
    a_en = 1'b1;
    b_en = 1'b1;
    exp_q.push_back({1'b1, 8'hD1});
    exp_q.push_back({1'b0, 8'hC1});
    exp_q.push_back({1'b1, 8'hD2});
    exp_q.push_back({1'b0, 8'hC2});
    refresh();
    at_neg();
    chk("prio_b_wins", b_ready, 1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("prio_stall_ready", {a_ready, b_ready}, 0);
      tick();
    end
    out_ready = 1'b1;
    at_neg();
    chk("prio_after_a_ready", a_ready, 1);
    chk("prio_after_b_ready", b_ready, 0);
    tick();
    drain("prio");

    // Reset mid-stream with 0x99 held and both sources valid.
    b_en = 1'b0;
    src_a = '{8'h99};
    refresh();
    cycle();
    out_ready = 1'b0;
    src_a.push_back(8'hE0);
    src_b = '{8'hE1};
    b_en = 1'b1;
    refresh();
    at_neg();
    chk("held_data", out_data, 8'h99);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    at_neg();
    chk("rst_ready_low", {a_ready, b_ready}, 0);
    tick();
    rst = 1'b0;
    exp_q.push_back({1'b0, 8'hE0});
    exp_q.push_back({1'b1, 8'hE1});
    at_neg();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_a_ready", a_ready, 1);
    chk("midrst_b_ready", b_ready, 0);
    tick();
    drain("midrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
